stats_fifo_reader: RTL and testbench

Drain side of the Ethernet statistics FIFO. The block pops one 448-bit statistics entry at a time from the synchronous FIFO, which has a read latency of 1 and a data_valid output. It serializes each entry onto an AXI4-Stream master as 448/C_AXIS_WIDTH beats, with tlast on the final beat. Sits between the stats collector's FIFO and the DMA/stream interconnect.

---
 rtl/stats_fifo_reader.sv | 132 +++++++++++++
 tb/tb_stats_fifo_reader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_fifo_reader.sv
// Drain side of the Ethernet statistics FIFO: pops 448-bit entries and streams them LSB word first.
// Optional entry counter (entries_sent/clear_count) is built when STATS_FIFO_READER_COUNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO; pop is issued from here
// WAIT  | pop in flight, waiting for fifo_valid to capture the entry
// SEND  | shifting the captured entry out, one beat per handshake
module stats_fifo_reader #(
    parameter int C_AXIS_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic                    fifo_valid,
    input  logic [447:0]            fifo_dout,
    output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy
`ifdef STATS_FIFO_READER_COUNT_EN
    ,
    input  logic                    clear_count,
    output logic [31:0]             entries_sent
`endif
);

    localparam int C_BEATS = 448 / C_AXIS_WIDTH;
    localparam int CNT_W   = $clog2(C_BEATS);

    if (!(C_AXIS_WIDTH == 8 || C_AXIS_WIDTH == 16 || C_AXIS_WIDTH == 32 || C_AXIS_WIDTH == 64))
    begin : g_width_check
        $error("stats_fifo_reader: C_AXIS_WIDTH must be 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [447:0]       shift;
    logic [CNT_W-1:0]   beat;
    logic               last_hs;

    assign last_hs      = (state == SEND) && m_axis_tvalid && m_axis_tready
                          && (beat == CNT_W'(C_BEATS - 1));
    assign m_axis_tdata = shift[C_AXIS_WIDTH-1:0];
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The pop is decoded straight from IDLE so the read returns during the
    // single WAIT cycle, which keeps the cadence at C_BEATS+2 cycles per entry.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (fifo_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift         <= '0;
            beat          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (fifo_valid) begin
                        shift         <= fifo_dout;
                        beat          <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= (C_BEATS == 1);
                    end
                end
                SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        shift         <= shift >> C_AXIS_WIDTH;
                        beat          <= beat + 1'b1;
                        m_axis_tvalid <= !last_hs;
                        m_axis_tlast  <= (beat == CNT_W'(C_BEATS - 2));
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STATS_FIFO_READER_COUNT_EN
    // Clear takes priority over a coincident last-beat increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_sent <= '0;
        end else if (clear_count) begin
            entries_sent <= '0;
        end else if (last_hs) begin
            entries_sent <= entries_sent + 32'd1;
        end
    end
`else
    // No entry counter in this build.
`endif

endmodule

// File: tb/tb_stats_fifo_reader.sv
// Bench for stats_fifo_reader: FIFO model, stream monitor and expected-beat scoreboard.
// The width-64 counter scenario is built only when STATS_FIFO_READER_COUNT_EN is defined.
module tb_stats_fifo_reader;
    localparam int W  = 32;
    localparam int NB = 448 / W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic           fifo_valid = 1'b0;
    logic [447:0]   fifo_dout = '0;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic           m_axis_tlast;
    logic           busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic [447:0] mem [16];
    int pushed = 0;
    int popped = 0;
    assign fifo_empty = (pushed == popped);

    always @(posedge clk) begin
        fifo_valid <= fifo_rd_en;
        if (fifo_rd_en) begin
            fifo_dout <= mem[popped % 16];
            popped    <= popped + 1;
        end
    end

`ifdef STATS_FIFO_READER_COUNT_EN
    logic        clear32 = 1'b0;
    logic [31:0] cnt32;
`endif

    stats_fifo_reader #(.C_AXIS_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_valid    (fifo_valid),
        .fifo_dout     (fifo_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy)
`ifdef STATS_FIFO_READER_COUNT_EN
        ,
        .clear_count   (clear32),
        .entries_sent  (cnt32)
`endif
    );

    // Monitor: records handshakes, pop cycles and any stall-stability violation.
    logic [W:0]   obs_q[$];
    logic [W:0]   exp_q[$];
    int           obs_cyc[$];
    int           rd_cyc[$];
    int           cyc = 0;
    int           unstable = 0;
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         pl = 1'b0;
    logic [W-1:0] pd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
                unstable++;
            if (m_axis_tvalid && m_axis_tready) begin
                obs_q.push_back({m_axis_tlast, m_axis_tdata});
                obs_cyc.push_back(cyc);
            end
        end
        pv = rst_n && m_axis_tvalid;
        pr = m_axis_tready;
        pl = m_axis_tlast;
        pd = m_axis_tdata;
    end

    task automatic clear_sb();
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
        rd_cyc.delete();
        unstable = 0;
    endtask

    task automatic push_entry(input logic [31:0] base);
        logic [447:0] e;
        logic [W-1:0] wd;
        e = '0;
        for (int i = 0; i < NB; i++) begin
            wd = W'(base + 32'(i));
            e[i*W +: W] = wd;
            exp_q.push_back({(i == NB - 1), wd});
        end
        mem[pushed % 16] = e;
        pushed++;
    endtask

    task automatic wait_beats(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h want=0", m_axis_tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        logic [W:0] got, want;
        clear_sb();
        m_axis_tready = 1'b1;
        push_entry(32'h0);
        @(negedge clk);
        enable = 1'b1;
        wait_beats(NB, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout beats=%0d want=%0d", obs_q.size(), NB); end
        checks++; if (obs_cyc[0] - rd_cyc[0] !== 2) begin errors++; $display("FAIL single_latency got=%0d want=2", obs_cyc[0] - rd_cyc[0]); end
        checks++; if (obs_cyc[NB-1] - obs_cyc[0] !== NB - 1) begin errors++; $display("FAIL single_consecutive got=%0d want=%0d", obs_cyc[NB-1] - obs_cyc[0], NB - 1); end
        for (int i = 0; i < NB; i++) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL single_beat%0d got=%h want=%h", i, got, want); end
        end
        repeat (5) @(negedge clk);
        checks++; if (rd_cyc.size() !== 1) begin errors++; $display("FAIL single_rd_count got=%0d want=1", rd_cyc.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b want=0", busy); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int k;
        logic [W:0] got, want;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        clear_sb();
        m_axis_tready = 1'b0;
        push_entry(32'h100);
        enable = 1'b1;
        ok = 1'b0;
        k = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            m_axis_tready = pat[k % 4];
            k++;
            if (obs_q.size() >= NB) begin
                ok = 1'b1;
                break;
            end
        end
        m_axis_tready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout beats=%0d want=%0d", obs_q.size(), NB); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable violations=%0d want=0", unstable); end
        checks++; if (rd_cyc.size() !== 1) begin errors++; $display("FAIL bp_rd_count got=%0d want=1", rd_cyc.size()); end
        for (int i = 0; i < NB; i++) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL bp_beat%0d got=%h want=%h", i, got, want); end
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [W:0] got, want;
        clear_sb();
        m_axis_tready = 1'b1;
        push_entry(32'h200);
        push_entry(32'h300);
        push_entry(32'h400);
        @(negedge clk);
        enable = 1'b1;
        wait_beats(3 * NB, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout beats=%0d want=%0d", obs_q.size(), 3 * NB); end
        checks++; if (rd_cyc.size() !== 3) begin errors++; $display("FAIL b2b_rd_count got=%0d want=3", rd_cyc.size()); end
        checks++; if (rd_cyc[1] - rd_cyc[0] !== NB + 2) begin errors++; $display("FAIL b2b_spacing1 got=%0d want=%0d", rd_cyc[1] - rd_cyc[0], NB + 2); end
        checks++; if (rd_cyc[2] - rd_cyc[1] !== NB + 2) begin errors++; $display("FAIL b2b_spacing2 got=%0d want=%0d", rd_cyc[2] - rd_cyc[1], NB + 2); end
        for (int i = 0; i < 3 * NB; i++) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL b2b_beat%0d got=%h want=%h", i, got, want); end
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        bit ok;
        logic [W:0] got, want;
        clear_sb();
        m_axis_tready = 1'b1;
        push_entry(32'h600);
        push_entry(32'h700);
        @(negedge clk);
        enable = 1'b1;
        wait_beats(6, 100, ok);
        enable = 1'b0;
        wait_beats(NB, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_entry1 beats=%0d want=%0d", obs_q.size(), NB); end
        repeat (20) @(negedge clk);
        checks++; if (rd_cyc.size() !== 1) begin errors++; $display("FAIL endrop_rd_held got=%0d want=1", rd_cyc.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy got=%b want=0", busy); end
        enable = 1'b1;
        wait_beats(2 * NB, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_entry2 beats=%0d want=%0d", obs_q.size(), 2 * NB); end
        checks++; if (rd_cyc.size() !== 2) begin errors++; $display("FAIL endrop_rd_count got=%0d want=2", rd_cyc.size()); end
        for (int i = 0; i < 2 * NB; i++) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL endrop_beat%0d got=%h want=%h", i, got, want); end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [W:0] got, want;
        clear_sb();
        m_axis_tready = 1'b1;
        push_entry(32'h500);
        @(negedge clk);
        enable = 1'b1;
        wait_beats(8, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach beats=%0d want=8", obs_q.size()); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got=%b want=0", m_axis_tvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_tlast got=%b want=0", m_axis_tlast); end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL rstmid_no_output beats=%0d want=8", obs_q.size()); end
        checks++; if (rd_cyc.size() !== 1) begin errors++; $display("FAIL rstmid_rd_count got=%0d want=1", rd_cyc.size()); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_idle_tvalid got=%b want=0", m_axis_tvalid); end
        for (int i = 0; i < 8; i++) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL rstmid_beat%0d got=%h want=%h", i, got, want); end
        end
        enable = 1'b0;
        clear_sb();
    endtask

`ifdef STATS_FIFO_READER_COUNT_EN
    localparam int W64  = 64;
    localparam int NB64 = 448 / W64;

    logic             enable_w = 1'b0;
    logic             empty_w;
    logic             rd_w;
    logic             valid_w = 1'b0;
    logic [447:0]     dout_w = '0;
    logic [W64-1:0]   tdata_w;
    logic             tvalid_w;
    logic             tready_w = 1'b0;
    logic             tlast_w;
    logic             busy_w;
    logic             clear_w = 1'b0;
    logic [31:0]      cnt_w;
    logic [447:0]     mem_w [4];
    int               pushed_w = 0;
    int               popped_w = 0;
    logic [W64:0]     exp_w[$];

    assign empty_w = (pushed_w == popped_w);

    always @(posedge clk) begin
        valid_w <= rd_w;
        if (rd_w) begin
            dout_w   <= mem_w[popped_w % 4];
            popped_w <= popped_w + 1;
        end
    end

    stats_fifo_reader #(.C_AXIS_WIDTH(W64)) dut64 (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable_w),
        .fifo_empty    (empty_w),
        .fifo_rd_en    (rd_w),
        .fifo_valid    (valid_w),
        .fifo_dout     (dout_w),
        .m_axis_tdata  (tdata_w),
        .m_axis_tvalid (tvalid_w),
        .m_axis_tready (tready_w),
        .m_axis_tlast  (tlast_w),
        .busy          (busy_w),
        .clear_count   (clear_w),
        .entries_sent  (cnt_w)
    );

    task automatic test_count64();
        logic [447:0] e;
        logic [W64:0] got, want;
        int nb, ent;
        bit cnt1_checked;
        checks++; if (cnt_w !== 32'd0) begin errors++; $display("FAIL cnt_reset got=%0d want=0", cnt_w); end
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j < 14; j++) e[j*32 +: 32] = $urandom;
            for (int j = 0; j < NB64; j++) exp_w.push_back({(j == NB64 - 1), e[j*W64 +: W64]});
            mem_w[pushed_w % 4] = e;
            pushed_w++;
        end
        tready_w = 1'b1;
        @(negedge clk);
        enable_w = 1'b1;
        nb = 0;
        ent = 0;
        cnt1_checked = 1'b0;
        for (int k = 0; k < 100 && ent < 2; k++) begin
            @(negedge clk);
            #1;
            if (ent == 1 && !cnt1_checked) begin
                cnt1_checked = 1'b1;
                checks++; if (cnt_w !== 32'd1) begin errors++; $display("FAIL cnt_after_first got=%0d want=1", cnt_w); end
            end
            if (tvalid_w && tready_w) begin
                nb++;
                got = {tlast_w, tdata_w};
                want = exp_w.pop_front();
                checks++; if (got !== want) begin errors++; $display("FAIL w64_beat%0d got=%h want=%h", nb - 1, got, want); end
                if (tlast_w) begin
                    ent++;
                    checks++; if (nb !== NB64 * ent) begin errors++; $display("FAIL w64_beats_at_tlast got=%0d want=%0d", nb, NB64 * ent); end
                    if (ent == 2) clear_w = 1'b1;
                end
            end
        end
        checks++; if (ent !== 2) begin errors++; $display("FAIL w64_timeout entries=%0d want=2", ent); end
        @(posedge clk);
        #1;
        clear_w = 1'b0;
        @(negedge clk);
        checks++; if (cnt_w !== 32'd0) begin errors++; $display("FAIL cnt_clear_wins got=%0d want=0", cnt_w); end
        enable_w = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
`ifdef STATS_FIFO_READER_COUNT_EN
        test_count64();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
